// File: rtl/hex_share_ctrl.sv
// hex_share_ctrl: round-robin time-sharing of one 2-bit-to-7-segment decoder
// among NREQ requesters, each owning one held HEX display register.
module hex_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       val,
    output logic [1:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [7*NREQ-1:0]       hex,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [GW-1:0]     r_ptr;
    logic [GW-1:0]     r_gidx;
    logic [1:0]        r_dec;
    logic [7*NREQ-1:0] r_hex;
    logic [NREQ-1:0]   r_ack;
    logic [GW-1:0]     w_grant;
    logic [GW-1:0]     w_idx;
    logic              w_any;

    // Scan from farthest to nearest so the nearest set bit after the pointer wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = GW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= GW'(NREQ - 1);
            r_gidx  <= '0;
            r_dec   <= 2'b00;
            r_hex   <= {NREQ{7'b1111111}};
            r_ack   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any) begin
                r_dec   <= val[2*w_grant +: 2];
                r_gidx  <= w_grant;
                r_ptr   <= w_grant;
                r_cnt   <= CW'(SETTLE - 1);
                r_state <= S_DRIVE;
            end
        end else if (r_state == S_DRIVE) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_hex[7*r_gidx +: 7] <= dec_out;
                r_ack                <= NREQ'(1) << r_gidx;
                r_state              <= S_ACK;
            end
        end else begin
            r_ack   <= '0;
            r_state <= S_IDLE;
        end
    end

    assign dec_in    = r_dec;
    assign hex       = r_hex;
    assign ack       = r_ack;
    assign grant_idx = r_gidx;
    assign busy      = r_state != S_IDLE;
endmodule
